// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Round-robin arbiter between two N-bit word producers, feeding the UART one
// byte at a time, MSB byte first. A word is never interrupted, and each
// producer is acknowledged exactly once per captured word.
// Build option: define UART_SCHED_HDR_EN to prepend a header byte
// (0xA0 | grant) to every word. The ports are the same in both builds.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no word held; arbitrate and capture when a producer is valid
// SEND       | issue the next byte as soon as the UART is not transmitting
// WAIT_START | byte issued; wait for is_transmitting to rise (bounded)
// WAIT_DONE  | UART busy with the byte; wait for is_transmitting to fall
module uart_tx_scheduler #(
    parameter int N        = 256,
    parameter int CNT_W    = 6,
    parameter int START_TO = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_data,
    output logic         req1_ready,
    input  logic         is_transmitting,
    output logic [7:0]   tx_byte,
    output logic         tx_valid,
    output logic         busy,
    output logic         grant
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

`ifdef UART_SCHED_HDR_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    localparam int               NBYTES  = (N / 8) + (HDR_EN ? 1 : 0);
    localparam logic [CNT_W-1:0] TOTAL   = CNT_W'(NBYTES);
    localparam int               TO_W    = (START_TO > 1) ? $clog2(START_TO) : 1;
    // The start timer is a down-counter; loading START_TO-1 and exiting on
    // zero keeps the FSM in WAIT_START for START_TO cycles.
    localparam logic [TO_W-1:0]  TO_LOAD = TO_W'(START_TO - 1);

    state_t           state_q, state_d;
    logic [N-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_d;
    logic             req0_ready_d, req1_ready_d;
    logic [7:0]       tx_byte_d;
    logic             tx_valid_d;

    logic             pick;
    logic             last_byte;
    logic             hdr_slot;
    logic [7:0]       hdr_byte;

    // With both producers valid, favour the one not granted last.
    assign pick      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign last_byte = (cnt_q == TOTAL);
    assign hdr_slot  = HDR_EN && (cnt_q == '0);
    assign hdr_byte  = {7'b1010000, grant};

    // Next-state and next-output decode; the outputs are registered below.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        to_d         = to_q;
        last_grant_d = last_grant_q;
        grant_d      = grant;
        req0_ready_d = 1'b0;
        req1_ready_d = 1'b0;
        tx_byte_d    = tx_byte;
        tx_valid_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    shift_d      = pick ? req1_data : req0_data;
                    grant_d      = pick;
                    last_grant_d = pick;
                    cnt_d        = '0;
                    req0_ready_d = ~pick;
                    req1_ready_d = pick;
                    state_d      = SEND;
                end
            end

            SEND: begin
                if (!is_transmitting) begin
                    tx_valid_d = 1'b1;
                    if (hdr_slot) begin
                        tx_byte_d = hdr_byte;
                    end else begin
                        tx_byte_d = shift_q[N-1 -: 8];
                        shift_d   = {shift_q[N-9:0], 8'h00};
                    end
                    cnt_d   = cnt_q + 1'b1;
                    to_d    = TO_LOAD;
                    state_d = WAIT_START;
                end
            end

            WAIT_START: begin
                if (is_transmitting) begin
                    state_d = WAIT_DONE;
                end else if (to_q == '0) begin
                    // UART never acknowledged: count the byte as sent.
                    state_d = last_byte ? IDLE : SEND;
                end else begin
                    to_d = to_q - 1'b1;
                end
            end

            WAIT_DONE: begin
                if (!is_transmitting) begin
                    state_d = last_byte ? IDLE : SEND;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            to_q         <= '0;
            last_grant_q <= 1'b1;
            grant        <= 1'b0;
            req0_ready   <= 1'b0;
            req1_ready   <= 1'b0;
            tx_byte      <= 8'h00;
            tx_valid     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            to_q         <= to_d;
            last_grant_q <= last_grant_d;
            grant        <= grant_d;
            req0_ready   <= req0_ready_d;
            req1_ready   <= req1_ready_d;
            tx_byte      <= tx_byte_d;
            tx_valid     <= tx_valid_d;
            busy         <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (N=32). Expected bytes are listed by
// hand; with UART_SCHED_HDR_EN defined the header byte is added in front.
module tb_uart_tx_scheduler;

    localparam int N        = 32;
    localparam int CNT_W    = 6;
    localparam int START_TO = 16;
    localparam int HOLD     = 5;
`ifdef UART_SCHED_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int NB = N / 8 + HDR;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req0_valid = 1'b0;
    logic [N-1:0] req0_data = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [N-1:0] req1_data = '0;
    logic         req1_ready;
    logic         is_transmitting = 1'b0;
    logic [7:0]   tx_byte;
    logic         tx_valid;
    logic         busy;
    logic         grant;

    int checks = 0;
    int failures = 0;

    bit req1_sticky = 1'b0;
    int uart_mode = 0;

    int         cyc = 0;
    logic [7:0] tx_bytes[$];
    int         tx_times[$];
    logic       tx_grant[$];
    int         fall_times[$];
    int         gaps[$];
    int         rdy0_n = 0;
    int         rdy1_n = 0;
    int         viol = 0;
    int         low_run = 0;
    int         uart_cnt = 0;
    logic       prev_txv = 1'b0;
    logic       prev_busy = 1'b0;

    uart_tx_scheduler #(.N(N), .CNT_W(CNT_W), .START_TO(START_TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_valid     (req0_valid),
        .req0_data      (req0_data),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_data      (req1_data),
        .req1_ready     (req1_ready),
        .is_transmitting(is_transmitting),
        .tx_byte        (tx_byte),
        .tx_valid       (tx_valid),
        .busy           (busy),
        .grant          (grant)
    );

    always #5 clk = ~clk;

    // Monitor followed by the UART model, both on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            uart_cnt        = 0;
            is_transmitting = 1'b0;
            prev_txv        = 1'b0;
            prev_busy       = 1'b0;
            low_run         = 0;
        end else begin
            if (tx_valid) begin
                tx_bytes.push_back(tx_byte);
                tx_times.push_back(cyc);
                tx_grant.push_back(grant);
                if (prev_txv || is_transmitting) viol++;
            end
            if (req0_ready) rdy0_n++;
            if (req1_ready) rdy1_n++;
            if (prev_busy && !busy) fall_times.push_back(cyc);
            if (busy) begin
                if (low_run > 0) gaps.push_back(low_run);
                low_run = 0;
            end else begin
                low_run++;
            end
            prev_txv  = tx_valid;
            prev_busy = busy;
            if (tx_valid && uart_mode == 0) uart_cnt = HOLD;
            else if (uart_cnt > 0) uart_cnt--;
            is_transmitting = (uart_cnt != 0);
        end
    end

    task automatic step();
        @(negedge clk);
        if (req0_ready) req0_valid = 1'b0;
        if (req1_ready && !req1_sticky) req1_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (2) step();
    endtask

    task automatic wait_ready(input bit which, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if ((which ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        req1_sticky = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx_byte: got %0h expected 0", tx_byte); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (grant !== 1'b0) begin failures++; $display("FAIL reset_grant: got %b expected 0", grant); end
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_word();
        logic [7:0] eb[$];
        int base, r0, r1, nf, sp, fl, lt;
        bit ok;
        eb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        if (HDR != 0) eb.push_front(8'hA0);
        base = tx_bytes.size(); r0 = rdy0_n; r1 = rdy1_n; nf = fall_times.size();
        uart_mode  = 0;
        req0_data  = 32'hDEADBEEF;
        req0_valid = 1'b1;
        wait_ready(1'b0, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_ready: req0_ready not seen in 20 cycles"); end
        wait_idle(400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_done: busy still high after 400 cycles"); end
        settle();
        checks++; if (rdy0_n - r0 !== 1 || rdy1_n - r1 !== 0) begin failures++; $display("FAIL single_ready_count: got %0d/%0d expected 1/0", rdy0_n - r0, rdy1_n - r1); end
        checks++; if (tx_bytes.size() - base !== NB) begin failures++; $display("FAIL single_pulses: got %0d expected %0d", tx_bytes.size() - base, NB); end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (tx_bytes.size() <= base + i || tx_bytes[base + i] !== eb[i]) begin
                failures++; $display("FAIL single_byte%0d: got %0h expected %0h", i, (tx_bytes.size() > base + i) ? tx_bytes[base + i] : 8'hxx, eb[i]);
            end
        end
        sp = (tx_times.size() > base + 1) ? tx_times[base + 1] - tx_times[base] : -1;
        checks++; if (sp !== HOLD + 2) begin failures++; $display("FAIL single_spacing: got %0d expected %0d", sp, HOLD + 2); end
        fl = (fall_times.size() > nf) ? fall_times[nf] : -1;
        lt = (tx_times.size() >= base + NB) ? tx_times[base + NB - 1] : -100;
        checks++; if (fl !== lt + HOLD + 1) begin failures++; $display("FAIL single_busy_fall: got cycle %0d expected %0d", fl, lt + HOLD + 1); end
    endtask

    task automatic test_req1_word();
        logic [7:0] eb[$];
        int base;
        bit ok;
        eb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        if (HDR != 0) eb.push_front(8'hA1);
        base = tx_bytes.size();
        req1_data  = 32'hDEADBEEF;
        req1_valid = 1'b1;
        wait_ready(1'b1, 20, ok);
        checks++; if (!ok || grant !== 1'b1) begin failures++; $display("FAIL req1_grant: ready=%b grant=%b expected 1/1", ok, grant); end
        wait_idle(400, ok);
        settle();
        checks++; if (!ok || tx_bytes.size() - base !== NB) begin failures++; $display("FAIL req1_pulses: got %0d expected %0d", tx_bytes.size() - base, NB); end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (tx_bytes.size() <= base + i || tx_bytes[base + i] !== eb[i]) begin
                failures++; $display("FAIL req1_byte%0d: got %0h expected %0h", i, (tx_bytes.size() > base + i) ? tx_bytes[base + i] : 8'hxx, eb[i]);
            end
        end
    endtask

    task automatic test_both_from_reset();
        logic [7:0] eb[$];
        logic [7:0] tail[$];
        int base;
        bit done, bad0, bad1;
        do_reset();
        eb   = '{8'h11, 8'h22, 8'h33, 8'h44};
        tail = '{8'h55, 8'h66, 8'h77, 8'h88};
        if (HDR != 0) begin
            eb.push_front(8'hA0);
            eb.push_back(8'hA1);
        end
        foreach (tail[k]) eb.push_back(tail[k]);
        base = tx_bytes.size();
        req0_data = 32'h11223344; req1_data = 32'h55667788;
        req0_valid = 1'b1; req1_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 800; i++) begin
            step();
            if (!req0_valid && !req1_valid && busy === 1'b0) begin done = 1'b1; break; end
        end
        checks++; if (!done) begin failures++; $display("FAIL both_done: words not finished in 800 cycles"); end
        settle();
        checks++; if (tx_bytes.size() - base !== 2 * NB) begin failures++; $display("FAIL both_pulses: got %0d expected %0d", tx_bytes.size() - base, 2 * NB); end
        for (int i = 0; i < 2 * NB; i++) begin
            checks++;
            if (tx_bytes.size() <= base + i || tx_bytes[base + i] !== eb[i]) begin
                failures++; $display("FAIL both_byte%0d: got %0h expected %0h", i, (tx_bytes.size() > base + i) ? tx_bytes[base + i] : 8'hxx, eb[i]);
            end
        end
        bad0 = 1'b0; bad1 = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (tx_grant.size() <= base + NB + i) begin bad0 = 1'b1; bad1 = 1'b1; end
            else begin
                if (tx_grant[base + i] !== 1'b0) bad0 = 1'b1;
                if (tx_grant[base + NB + i] !== 1'b1) bad1 = 1'b1;
            end
        end
        checks++; if (bad0) begin failures++; $display("FAIL both_grant_first: grant not 0 on every byte of first word, expected 0"); end
        checks++; if (bad1) begin failures++; $display("FAIL both_grant_second: grant not 1 on every byte of second word, expected 1"); end
        checks++; if (gaps.size() == 0 || gaps[gaps.size() - 1] !== 1) begin failures++; $display("FAIL both_busy_gap: got %0d expected 1", (gaps.size() > 0) ? gaps[gaps.size() - 1] : -1); end
    endtask

    task automatic test_rr_fairness();
        logic order[$];
        logic gseen[$];
        logic [7:0] eb[$];
        int base, n1;
        bit armed, done, ord_bad;
        eb = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        if (HDR != 0) eb.push_front(8'hA0);
        base = tx_bytes.size();
        n1 = 0; armed = 1'b0; done = 1'b0;
        req1_data = 32'h55667788; req1_sticky = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            step();
            if (req0_ready === 1'b1) begin order.push_back(1'b0); gseen.push_back(grant); end
            if (req1_ready === 1'b1) begin
                order.push_back(1'b1); gseen.push_back(grant); n1++;
                if (n1 == 2) begin req1_sticky = 1'b0; req1_valid = 1'b0; end
            end
            if (n1 == 1 && tx_valid === 1'b1 && !armed) begin
                req0_data = 32'h0A0B0C0D; req0_valid = 1'b1; armed = 1'b1;
            end
            if (n1 >= 2 && busy === 1'b0) begin done = 1'b1; break; end
        end
        checks++; if (!done) begin failures++; $display("FAIL rr_done: sequence not finished in 1200 cycles"); end
        settle();
        ord_bad = (order.size() != 3) || order[0] !== 1'b1 || order[1] !== 1'b0 || order[2] !== 1'b1;
        checks++; if (ord_bad) begin failures++; $display("FAIL rr_order: got %0d grants starting %b%b expected 1,0,1", order.size(), (order.size() > 0) ? order[0] : 1'bx, (order.size() > 1) ? order[1] : 1'bx); end
        ord_bad = (gseen.size() != 3) || gseen[0] !== 1'b1 || gseen[1] !== 1'b0 || gseen[2] !== 1'b1;
        checks++; if (ord_bad) begin failures++; $display("FAIL rr_grant_out: grant output at ready did not read 1,0,1"); end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (tx_bytes.size() <= base + NB + i || tx_bytes[base + NB + i] !== eb[i]) begin
                failures++; $display("FAIL rr_mid_byte%0d: got %0h expected %0h", i, (tx_bytes.size() > base + NB + i) ? tx_bytes[base + NB + i] : 8'hxx, eb[i]);
            end
        end
    endtask

    task automatic test_start_timeout();
        logic [7:0] eb[$];
        int base, nf, sp, fl, lt;
        bit ok;
        eb = '{8'h89, 8'hAB, 8'hCD, 8'hEF};
        if (HDR != 0) eb.push_front(8'hA0);
        base = tx_bytes.size(); nf = fall_times.size();
        uart_mode  = 1;
        req0_data  = 32'h89ABCDEF;
        req0_valid = 1'b1;
        wait_ready(1'b0, 20, ok);
        wait_idle(600, ok);
        checks++; if (!ok) begin failures++; $display("FAIL timeout_done: busy still high after 600 cycles"); end
        settle();
        uart_mode = 0;
        checks++; if (tx_bytes.size() - base !== NB) begin failures++; $display("FAIL timeout_pulses: got %0d expected %0d", tx_bytes.size() - base, NB); end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (tx_bytes.size() <= base + i || tx_bytes[base + i] !== eb[i]) begin
                failures++; $display("FAIL timeout_byte%0d: got %0h expected %0h", i, (tx_bytes.size() > base + i) ? tx_bytes[base + i] : 8'hxx, eb[i]);
            end
        end
        for (int i = 1; i < NB; i++) begin
            sp = (tx_times.size() > base + i) ? tx_times[base + i] - tx_times[base + i - 1] : -1;
            checks++; if (sp !== START_TO + 1) begin failures++; $display("FAIL timeout_spacing%0d: got %0d expected %0d", i, sp, START_TO + 1); end
        end
        fl = (fall_times.size() > nf) ? fall_times[nf] : -1;
        lt = (tx_times.size() >= base + NB) ? tx_times[base + NB - 1] : -100;
        checks++; if (fl !== lt + START_TO) begin failures++; $display("FAIL timeout_busy_fall: got cycle %0d expected %0d", fl, lt + START_TO); end
    endtask

    task automatic test_mid_word_reset();
        logic [7:0] eb[$];
        int base, base2, seen;
        bit ok;
        eb = '{8'h01, 8'h02, 8'h03, 8'h04};
        if (HDR != 0) eb.push_front(8'hA0);
        base = tx_bytes.size();
        uart_mode  = 0;
        req0_data  = 32'hCAFEF00D;
        req0_valid = 1'b1;
        wait_ready(1'b0, 20, ok);
        seen = 0;
        for (int i = 0; i < 100 && seen < 2; i++) begin
            step();
            if (tx_valid === 1'b1) seen++;
        end
        step(); step();
        rst_n = 1'b0;
        #1;
        checks++; if (tx_byte !== 8'h00 || tx_valid !== 1'b0) begin failures++; $display("FAIL midreset_tx: got %0h/%b expected 00/0", tx_byte, tx_valid); end
        checks++; if (busy !== 1'b0 || grant !== 1'b0) begin failures++; $display("FAIL midreset_busy_grant: got %b/%b expected 0/0", busy, grant); end
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL midreset_ready: got %b%b expected 00", req0_ready, req1_ready); end
        repeat (3) step();
        base2 = tx_bytes.size();
        checks++; if (base2 - base !== 2) begin failures++; $display("FAIL midreset_sent_before: got %0d expected 2", base2 - base); end
        rst_n = 1'b1;
        step();
        req0_data  = 32'h01020304;
        req0_valid = 1'b1;
        wait_ready(1'b0, 20, ok);
        wait_idle(400, ok);
        settle();
        checks++; if (!ok || tx_bytes.size() - base2 !== NB) begin failures++; $display("FAIL midreset_pulses: got %0d expected %0d", tx_bytes.size() - base2, NB); end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (tx_bytes.size() <= base2 + i || tx_bytes[base2 + i] !== eb[i]) begin
                failures++; $display("FAIL midreset_byte%0d: got %0h expected %0h", i, (tx_bytes.size() > base2 + i) ? tx_bytes[base2 + i] : 8'hxx, eb[i]);
            end
        end
        checks++; if (viol !== 0) begin failures++; $display("FAIL protocol: got %0d overlapping or back-to-back tx_valid events expected 0", viol); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_req1_word();
        test_both_from_reset();
        test_rr_fairness();
        test_start_timeout();
        test_mid_word_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Controller in front of the UART transmitter. Arbitrates round-robin between two N-bit word producers (RSA result path and status/echo path), accepts one word at a time, and sequences it MSB-byte-first into the UART as single-byte requests. It issues each byte only after the UART has started and then finished the previous one. It supersedes ad-hoc stall logic: words are never interrupted, and a producer is acknowledged exactly once per word.

## Interface
- `N`, 256: word width in bits; must be a multiple of 8, N ≥ 16.
- `CNT_W`, 6: byte-counter width; must hold N/8 + 1.
- `START_TO`, 16: cycles to wait for `is_transmitting` to rise after a byte request.

- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req0_valid`  in  1  producer 0 has a word; held until `req0_ready`.
- `req0_data`  in  N  producer 0 word; stable while `req0_valid`.
- `req0_ready`  out  1  one-cycle acknowledge: word 0 captured.
- `req1_valid`  in  1  as req0.
- `req1_data`  in  N  as req0.
- `req1_ready`  out  1  as req0.
- `is_transmitting`  in  1  UART busy flag.
- `tx_byte`  out  8  byte to UART; valid while `tx_valid`.
- `tx_valid`  out  1  one-cycle byte request pulse.
- `busy`  out  1  high from capture until last byte completes.
- `grant`  out  1  source of current/last word (0 or 1).

## Operation
- States: IDLE, SEND, WAIT_START, WAIT_DONE.
- IDLE: if any `reqX_valid` is high, pick one via round-robin. Priority goes to the requester not granted last. When both are valid after reset, req0 wins (last-grant resets to 1).
  - Capture data into the shift register, set `grant`, clear the byte counter, pulse `reqX_ready` and go to SEND.
- SEND: if `is_transmitting` is low, drive `tx_byte` = shift[N-1:N-8] and pulse `tx_valid`, then shift left 8, increment the counter, and go to WAIT_START. Otherwise hold.
- WAIT_START: wait for `is_transmitting`=1, then go to WAIT_DONE. If it is not seen within START_TO cycles, treat the byte as sent and apply the WAIT_DONE exit directly.
- WAIT_DONE: on `is_transmitting`=0, if counter == total bytes go to IDLE, else go to SEND.
- Total bytes = N/8, or N/8+1 when the header is enabled.
- `busy` = state ≠ IDLE.
- `tx_valid` never asserts outside SEND→WAIT_START. There is never more than one outstanding byte.
- Valid inputs are ignored outside IDLE. A valid dropped before ready is not captured and no ready is given.
- Reset, including mid-word: the word is discarded and the FSM goes to IDLE. Outputs reset as follows:
  - `tx_byte`=0x00, `tx_valid`=0
  - `req0_ready`=`req1_ready`=0
  - `busy`=0, `grant`=0
  - internal last-grant=1

## Timing
- Valid sampled high in IDLE at edge E0: data captured at E0, and `reqX_ready` is high for the cycle after E0.
- First `tx_valid` is at edge E1 at the earliest, when `is_transmitting` is low at E1.
- Byte spacing: at least 3 cycles (SEND, WAIT_START, WAIT_DONE), otherwise set by the UART.
- Return to IDLE occurs in the cycle after the final falling edge of `is_transmitting`.
- A queued word is captured in the next cycle, and `busy` drops for exactly one cycle between words.
- All outputs are registered.

## Configuration
- `UART_SCHED_HDR_EN` defined: a header byte, 0xA0 | grant, is sent before the word's bytes. The word is N/8+1 bytes long.
- Undefined: no header, and a word is exactly N/8 bytes.
- Ports are identical in both builds.

## Test plan
- N=32, no header. req0 = 0xDEADBEEF, and the UART model holds busy for 5 cycles per byte. Required: one `req0_ready` pulse; bytes DE, AD, BE, EF in order; exactly 4 `tx_valid` pulses; `busy` falls after the 4th completion.
- Both valid from reset: req0 = 0x11223344, req1 = 0x55667788. Required: req0's word goes first, then req1's. `grant` is 0 then 1, and the bytes do not interleave.
- req1 is continuously valid and req0 is asserted mid-word of req1. Required: req0 is granted next, and req1 is not granted twice in a row.
- The UART model never raises `is_transmitting`. Required: each byte advances after START_TO (16) cycles, and the word completes with 4 pulses.
- Assert `rst_n`=0 after byte 2 of 0xCAFEF00D. Required: outputs take reset values immediately. After release, a new word 0x01020304 is sent cleanly as 01, 02, 03, 04.
- `UART_SCHED_HDR_EN` defined, req1 = 0xDEADBEEF. Required: the bytes are A1, DE, AD, BE, EF.
